rf_read_sched: RTL and testbench

Sequencer and arbiter for the core's 1R1W register memory. Serializes each core operand-fetch request (rs1, rs2) into two consecutive single-port reads and returns both operands together. Shares the read and write ports with a debug access port, which a starvation counter keeps from being locked out. Writeback forwarding into in-flight reads is optional. Sits between decode/writeback and the register storage array.

---
 rtl/rf_read_sched_pkg.sv | 17 +
 rtl/rf_read_sched_if.sv | 56 +++++
 rtl/rf_sched_arb.sv | 37 +++
 rtl/rf_read_sched.sv | 146 ++++++++++++++
 tb/tb_rf_read_sched.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_read_sched_pkg.sv
// Shared definitions for the register-file read scheduler and the core pipeline:
// FSM state encoding, default widths and the debug starvation limit.
package rf_sched_pkg;

   localparam int XLEN_DEFAULT   = 32;
   localparam int REG_AW_DEFAULT = 5;
   localparam int STARVE_LIMIT   = 2;
   localparam int STARVE_W       = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RS1  = 2'd1,
      RS2  = 2'd2,
      DBG  = 2'd3
   } sched_state_e;

endpackage

// File: rtl/rf_read_sched_if.sv
// Bundle of core fetch, writeback, debug and storage-port signals around the read scheduler.
// slave is the scheduler's view, master is the view of everything that talks to it.
interface rf_read_sched_if
   import rf_sched_pkg::*;
#(
   parameter int XLEN   = XLEN_DEFAULT,
   parameter int REG_AW = REG_AW_DEFAULT
);

   logic              core_req_valid;
   logic              core_req_ready;
   logic [REG_AW-1:0] core_rs1;
   logic [REG_AW-1:0] core_rs2;
   logic              core_rsp_valid;
   logic [XLEN-1:0]   core_rs1_v;
   logic [XLEN-1:0]   core_rs2_v;

   logic              wb_we;
   logic [REG_AW-1:0] wb_rd;
   logic [XLEN-1:0]   wb_v;

   logic              dbg_req_valid;
   logic              dbg_req_ready;
   logic [REG_AW-1:0] dbg_addr;
   logic              dbg_we;
   logic [XLEN-1:0]   dbg_wdata;
   logic              dbg_rsp_valid;
   logic [XLEN-1:0]   dbg_rdata;

   logic [REG_AW-1:0] mem_raddr;
   logic [XLEN-1:0]   mem_rdata;
   logic              mem_we;
   logic [REG_AW-1:0] mem_waddr;
   logic [XLEN-1:0]   mem_wdata;

   modport slave (
      input  core_req_valid, core_rs1, core_rs2,
      output core_req_ready, core_rsp_valid, core_rs1_v, core_rs2_v,
      input  wb_we, wb_rd, wb_v,
      input  dbg_req_valid, dbg_addr, dbg_we, dbg_wdata,
      output dbg_req_ready, dbg_rsp_valid, dbg_rdata,
      output mem_raddr, mem_we, mem_waddr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output core_req_valid, core_rs1, core_rs2,
      input  core_req_ready, core_rsp_valid, core_rs1_v, core_rs2_v,
      output wb_we, wb_rd, wb_v,
      output dbg_req_valid, dbg_addr, dbg_we, dbg_wdata,
      input  dbg_req_ready, dbg_rsp_valid, dbg_rdata,
      input  mem_raddr, mem_we, mem_waddr, mem_wdata,
      output mem_rdata
   );

endinterface

// File: rtl/rf_sched_arb.sv
// Two-requester arbiter: core wins by default, debug wins once it has been
// passed over STARVE_LIMIT times while waiting.
module rf_sched_arb
   import rf_sched_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic core_valid,
   input  logic dbg_valid,
   output logic grant_core,
   output logic grant_dbg
);

   logic [STARVE_W-1:0] starve_cnt;

   function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   always_comb begin
      grant_dbg  = en && dbg_valid &&
                   (!core_valid || (starve_cnt >= STARVE_W'(STARVE_LIMIT)));
      grant_core = en && core_valid && !grant_dbg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (grant_dbg) begin
         starve_cnt <= '0;
      end else if (grant_core && dbg_valid) begin
         starve_cnt <= sat_inc(starve_cnt);
      end
   end

endmodule

// File: rtl/rf_read_sched.sv
// Serializes core rs1/rs2 fetches onto the single read port and shares both ports
// with debug access. Optional writeback forwarding: define RF_SCHED_BYPASS_EN.
module rf_read_sched
   import rf_sched_pkg::*;
#(
   parameter int XLEN   = XLEN_DEFAULT,
   parameter int REG_AW = REG_AW_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   rf_read_sched_if.slave     bus
);

   sched_state_e      state;
   sched_state_e      state_nxt;
   logic              arb_en;
   logic              grant_core;
   logic              grant_dbg;
   logic              wb_act;
   logic              dbg_wr_go;
   logic [REG_AW-1:0] raddr;
   logic [XLEN-1:0]   rd_val;

   logic [REG_AW-1:0] rs1_p0;
   logic [REG_AW-1:0] rs2_p0;
   logic [REG_AW-1:0] dbg_addr_p0;
   logic              dbg_we_p0;
   logic [XLEN-1:0]   dbg_wdata_p0;
   logic [XLEN-1:0]   op1_p1;

   // Arbitration is frozen while reset is held so no request is taken then.
   assign arb_en = (state == IDLE) && !rst;
   assign wb_act = bus.wb_we && (bus.wb_rd != '0);

   rf_sched_arb u_arb (
      .clk        (clk),
      .rst        (rst),
      .en         (arb_en),
      .core_valid (bus.core_req_valid),
      .dbg_valid  (bus.dbg_req_valid),
      .grant_core (grant_core),
      .grant_dbg  (grant_dbg)
   );

   assign bus.core_req_ready = grant_core;
   assign bus.dbg_req_ready  = grant_dbg;
   assign bus.mem_raddr      = raddr;

   always_comb begin
      state_nxt = state;
      raddr     = '0;
      dbg_wr_go = 1'b0;
      case (state)
         IDLE: begin
            if (grant_core)     state_nxt = RS1;
            else if (grant_dbg) state_nxt = DBG;
         end
         RS1: begin
            raddr     = rs1_p0;
            state_nxt = RS2;
         end
         RS2: begin
            raddr     = rs2_p0;
            state_nxt = IDLE;
         end
         DBG: begin
            if (!dbg_we_p0) begin
               raddr     = dbg_addr_p0;
               state_nxt = IDLE;
            end else if (!wb_act) begin
               dbg_wr_go = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rd_val = bus.mem_rdata;
`ifdef RF_SCHED_BYPASS_EN
      if (wb_act && (bus.wb_rd == raddr)) rd_val = bus.wb_v;
`endif
      if (raddr == '0) rd_val = '0;
   end

   // Writeback owns the write port; a debug write only lands on a free cycle.
   always_comb begin
      bus.mem_we    = 1'b0;
      bus.mem_waddr = '0;
      bus.mem_wdata = '0;
      if (wb_act) begin
         bus.mem_we    = 1'b1;
         bus.mem_waddr = bus.wb_rd;
         bus.mem_wdata = bus.wb_v;
      end else if (dbg_wr_go && !rst && (dbg_addr_p0 != '0)) begin
         bus.mem_we    = 1'b1;
         bus.mem_waddr = dbg_addr_p0;
         bus.mem_wdata = dbg_wdata_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Stage p0: request capture at grant
   always_ff @(posedge clk) begin
      if (grant_core) begin
         rs1_p0 <= bus.core_rs1;
         rs2_p0 <= bus.core_rs2;
      end
      if (grant_dbg) begin
         dbg_addr_p0  <= bus.dbg_addr;
         dbg_we_p0    <= bus.dbg_we;
         dbg_wdata_p0 <= bus.dbg_wdata;
      end
   end

   // Stage p1: first operand held while rs2 is read
   always_ff @(posedge clk) begin
      if (state == RS1) op1_p1 <= rd_val;
   end

   // Stage p2: responses
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.core_rsp_valid <= 1'b0;
         bus.core_rs1_v     <= '0;
         bus.core_rs2_v     <= '0;
         bus.dbg_rsp_valid  <= 1'b0;
         bus.dbg_rdata      <= '0;
      end else begin
         bus.core_rsp_valid <= (state == RS2);
         bus.dbg_rsp_valid  <= (state == DBG) && (!dbg_we_p0 || !wb_act);
         if (state == RS2) begin
            bus.core_rs1_v <= op1_p1;
            bus.core_rs2_v <= rd_val;
         end
         if ((state == DBG) && !dbg_we_p0) bus.dbg_rdata <= rd_val;
         else if (dbg_wr_go)               bus.dbg_rdata <= '0;
      end
   end

endmodule

// File: tb/tb_rf_read_sched.sv
// Self-checking bench for rf_read_sched: directed scenarios plus random traffic,
// checked by a transaction-level register-file model feeding response scoreboards.
`timescale 1ns/1ps
module tb_rf_read_sched;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rf_read_sched_if #(.XLEN(32), .REG_AW(5)) bus ();
   rf_read_sched #(.XLEN(32), .REG_AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [31:0] tb_mem [32] = '{default: 32'h0};
   logic [31:0] ref_rf [32] = '{default: 32'h0};
   bit force_ones = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (bus.mem_we) tb_mem[bus.mem_waddr] <= bus.mem_wdata;
   assign bus.mem_rdata = force_ones ? 32'hFFFF_FFFF : tb_mem[bus.mem_raddr];

   task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int          due;
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;
   exp_t core_q[$];
   exp_t dbg_q[$];

   // Reference: register file contents plus the read/write timing the scheduler promises.
   function automatic logic [31:0] ref_read(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
`ifdef RF_SCHED_BYPASS_EN
      if (bus.wb_we && (bus.wb_rd == a)) return bus.wb_v;
`endif
      return ref_rf[a];
   endfunction

   int          starve_m = 0;
   bit          c_busy = 0, d_busy = 0, d_we_m = 0;
   int          c_phase = 0;
   logic [4:0]  c_rs1_m, c_rs2_m, d_addr_m;
   logic [31:0] c_v1_m, d_wdata_m;

   always @(negedge clk) begin : model
      bit idle, gc, gd, wb_act;
      wb_act = bus.wb_we && (bus.wb_rd != 5'd0);
      if (rst) begin
         c_busy = 0; d_busy = 0; starve_m = 0;
      end else begin
         idle = !c_busy && !d_busy;
         if (c_busy) begin
            if (c_phase == 1) begin
               c_v1_m = ref_read(c_rs1_m); c_phase = 2;
            end else begin
               core_q.push_back('{cyc + 1, c_v1_m, ref_read(c_rs2_m)}); c_busy = 0;
            end
         end
         if (d_busy && !d_we_m) begin
            dbg_q.push_back('{cyc + 1, ref_read(d_addr_m), 32'h0}); d_busy = 0;
         end else if (d_busy && !wb_act) begin
            if (d_addr_m != 5'd0) ref_rf[d_addr_m] = d_wdata_m;
            dbg_q.push_back('{cyc + 1, 32'h0, 32'h0}); d_busy = 0;
         end
         if (wb_act) ref_rf[bus.wb_rd] = bus.wb_v;
         gd = idle && bus.dbg_req_valid && (!bus.core_req_valid || starve_m >= 2);
         gc = idle && bus.core_req_valid && !gd;
         check("core_ready", bus.core_req_ready == gc, 32'(bus.core_req_ready), 32'(gc));
         check("dbg_ready", bus.dbg_req_ready == gd, 32'(bus.dbg_req_ready), 32'(gd));
         if (gd) starve_m = 0;
         else if (gc && bus.dbg_req_valid) starve_m++;
         if (gc) begin
            c_busy = 1; c_phase = 1; c_rs1_m = bus.core_rs1; c_rs2_m = bus.core_rs2;
         end
         if (gd) begin
            d_busy = 1; d_we_m = bus.dbg_we; d_addr_m = bus.dbg_addr; d_wdata_m = bus.dbg_wdata;
         end
      end
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (bus.core_rsp_valid) begin
         if (core_q.size() == 0) check("core_rsp_unexpected", 1'b0, 32'h1, 32'h0);
         else begin
            e = core_q.pop_front();
            check("core_rsp_cycle", cyc == e.due, 32'(cyc), 32'(e.due));
            check("core_rs1_v", bus.core_rs1_v == e.a, bus.core_rs1_v, e.a);
            check("core_rs2_v", bus.core_rs2_v == e.b, bus.core_rs2_v, e.b);
         end
      end
      if (bus.dbg_rsp_valid) begin
         if (dbg_q.size() == 0) check("dbg_rsp_unexpected", 1'b0, 32'h1, 32'h0);
         else begin
            e = dbg_q.pop_front();
            check("dbg_rsp_cycle", cyc == e.due, 32'(cyc), 32'(e.due));
            check("dbg_rdata", bus.dbg_rdata == e.a, bus.dbg_rdata, e.a);
         end
      end
      if (bus.mem_we) check("mem_we_x0", bus.mem_waddr != 5'd0, 32'(bus.mem_waddr), 32'h1);
      if (!rst && bus.wb_we && (bus.wb_rd != 5'd0))
         check("wb_write", bus.mem_we && (bus.mem_waddr == bus.wb_rd) && (bus.mem_wdata == bus.wb_v),
               bus.mem_wdata, bus.wb_v);
   end

   task automatic core_req(input logic [4:0] a, input logic [4:0] b, output int acc);
      @(posedge clk); #1;
      bus.core_req_valid = 1'b1; bus.core_rs1 = a; bus.core_rs2 = b;
      acc = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.core_req_ready) begin acc = cyc; break; end
      end
      if (acc < 0) check("core_accept_timeout", 1'b0, 32'h0, 32'h1);
      @(posedge clk); #1;
      bus.core_req_valid = 1'b0;
   endtask

   task automatic dbg_req(input logic [4:0] a, input bit we, input logic [31:0] d, output int acc);
      @(posedge clk); #1;
      bus.dbg_req_valid = 1'b1; bus.dbg_addr = a; bus.dbg_we = we; bus.dbg_wdata = d;
      acc = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.dbg_req_ready) begin acc = cyc; break; end
      end
      if (acc < 0) check("dbg_accept_timeout", 1'b0, 32'h0, 32'h1);
      @(posedge clk); #1;
      bus.dbg_req_valid = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int acc, start, first_d, ng, lat;
      bit got, seen_we, c_acc, d_acc;
      byte gseq [6];
      logic [31:0] exp_rs2;
      bus.core_req_valid = 0; bus.core_rs1 = 0; bus.core_rs2 = 0;
      bus.wb_we = 0; bus.wb_rd = 0; bus.wb_v = 0;
      bus.dbg_req_valid = 0; bus.dbg_addr = 0; bus.dbg_we = 0; bus.dbg_wdata = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_core_rsp_valid", bus.core_rsp_valid == 1'b0, 32'(bus.core_rsp_valid), 32'h0);
      check("rst_dbg_rsp_valid", bus.dbg_rsp_valid == 1'b0, 32'(bus.dbg_rsp_valid), 32'h0);
      check("rst_core_rs1_v", bus.core_rs1_v == 32'h0, bus.core_rs1_v, 32'h0);
      check("rst_core_rs2_v", bus.core_rs2_v == 32'h0, bus.core_rs2_v, 32'h0);
      check("rst_dbg_rdata", bus.dbg_rdata == 32'h0, bus.dbg_rdata, 32'h0);
      check("rst_mem_we", bus.mem_we == 1'b0, 32'(bus.mem_we), 32'h0);
      @(posedge clk); #1 rst = 1'b0;

      // Preload and a plain fetch
      dbg_req(5'd5, 1'b1, 32'h11, acc);
      dbg_req(5'd6, 1'b1, 32'h22, acc);
      repeat (3) @(posedge clk);
      core_req(5'd5, 5'd6, acc);
      repeat (3) @(negedge clk);
      check("fetch_rsp_n3", bus.core_rsp_valid == 1'b1 && cyc == acc + 3, 32'(cyc - acc), 32'h3);
      check("fetch_rs1", bus.core_rs1_v == 32'h11, bus.core_rs1_v, 32'h11);
      check("fetch_rs2", bus.core_rs2_v == 32'h22, bus.core_rs2_v, 32'h22);

      // x0 reads ignore storage; x0 debug write is acked but never written
      force_ones = 1'b1;
      core_req(5'd0, 5'd0, acc);
      repeat (3) @(negedge clk);
      check("x0_rsp", bus.core_rsp_valid == 1'b1, 32'(bus.core_rsp_valid), 32'h1);
      check("x0_rs1", bus.core_rs1_v == 32'h0, bus.core_rs1_v, 32'h0);
      check("x0_rs2", bus.core_rs2_v == 32'h0, bus.core_rs2_v, 32'h0);
      force_ones = 1'b0;
      dbg_req(5'd0, 1'b1, 32'hAB, acc);
      got = 0; seen_we = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.mem_we) seen_we = 1;
         if (bus.dbg_rsp_valid) begin got = 1; break; end
      end
      check("x0_dbg_ack", got == 1'b1, 32'(got), 32'h1);
      check("x0_dbg_no_we", seen_we == 1'b0, 32'(seen_we), 32'h0);

      // Writeback to x6 during the RS2 cycle of a fetch of x6
      repeat (2) @(posedge clk);
      core_req(5'd5, 5'd6, acc);
      @(posedge clk); #1;
      bus.wb_we = 1'b1; bus.wb_rd = 5'd6; bus.wb_v = 32'h99;
      @(posedge clk); #1;
      bus.wb_we = 1'b0;
      @(negedge clk);
`ifdef RF_SCHED_BYPASS_EN
      exp_rs2 = 32'h99;
`else
      exp_rs2 = 32'h22;
`endif
      check("bypass_rsp", bus.core_rsp_valid == 1'b1, 32'(bus.core_rsp_valid), 32'h1);
      check("bypass_rs2", bus.core_rs2_v == exp_rs2, bus.core_rs2_v, exp_rs2);

      // Both requesters held valid: debug must get every third grant
      repeat (3) @(posedge clk); #1;
      bus.core_req_valid = 1'b1; bus.core_rs1 = 5'd5; bus.core_rs2 = 5'd6;
      bus.dbg_req_valid = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 5'd6;
      start = cyc; ng = 0; first_d = -1;
      for (int i = 0; i < 40 && ng < 6; i++) begin
         @(negedge clk);
         if (bus.core_req_ready) begin gseq[ng] = "c"; ng++; end
         else if (bus.dbg_req_ready) begin
            gseq[ng] = "d"; ng++;
            if (first_d < 0) first_d = cyc;
         end
      end
      @(posedge clk); #1;
      bus.core_req_valid = 1'b0; bus.dbg_req_valid = 1'b0;
      check("grant_count", ng == 6, 32'(ng), 32'h6);
      for (int i = 0; i < 6; i++)
         check($sformatf("grant_order_%0d", i), gseq[i] == (((i % 3) == 2) ? "d" : "c"),
               32'(gseq[i]), ((i % 3) == 2) ? 32'h64 : 32'h63);
      check("dbg_wait", first_d >= 0 && (first_d + 2 - start) <= 8, 32'(first_d + 2 - start), 32'h8);

      // Debug write held off by three writeback cycles
      repeat (6) @(posedge clk);
      dbg_req(5'd7, 1'b1, 32'h55, acc);
      for (int k = 0; k < 3; k++) begin
         bus.wb_we = 1'b1; bus.wb_rd = 5'(9 + k); bus.wb_v = 32'h100 + 32'(k);
         @(posedge clk); #1;
      end
      bus.wb_we = 1'b0;
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.dbg_rsp_valid) begin lat = cyc - acc; break; end
      end
      check("dbg_wr_blocked_lat", lat == 5, 32'(lat), 32'h5);

      // Reset during RS2 drops the fetch; a new request is taken right after
      repeat (2) @(posedge clk);
      core_req(5'd5, 5'd6, acc);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.core_req_valid = 1'b1; bus.core_rs1 = 5'd1; bus.core_rs2 = 5'd2;
      @(negedge clk);
      check("rst_mid_no_rsp", bus.core_rsp_valid == 1'b0, 32'(bus.core_rsp_valid), 32'h0);
      check("rst_mid_rs1_v", bus.core_rs1_v == 32'h0, bus.core_rs1_v, 32'h0);
      check("rst_mid_rs2_v", bus.core_rs2_v == 32'h0, bus.core_rs2_v, 32'h0);
      check("rst_mid_accept", bus.core_req_ready == 1'b1, 32'(bus.core_req_ready), 32'h1);
      @(posedge clk); #1;
      bus.core_req_valid = 1'b0;

      // Random traffic
      c_acc = 1; d_acc = 1;
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         if (c_acc || !bus.core_req_valid) begin
            bus.core_req_valid = ($urandom_range(0, 2) != 0);
            bus.core_rs1 = 5'($urandom); bus.core_rs2 = 5'($urandom);
         end
         if (d_acc || !bus.dbg_req_valid) begin
            bus.dbg_req_valid = ($urandom_range(0, 2) == 0);
            bus.dbg_addr = 5'($urandom); bus.dbg_we = 1'($urandom); bus.dbg_wdata = $urandom;
         end
         bus.wb_we = ($urandom_range(0, 3) == 0);
         bus.wb_rd = 5'($urandom); bus.wb_v = $urandom;
         @(negedge clk);
         c_acc = bus.core_req_valid && bus.core_req_ready;
         d_acc = bus.dbg_req_valid && bus.dbg_req_ready;
      end
      @(posedge clk); #1;
      bus.core_req_valid = 0; bus.dbg_req_valid = 0; bus.wb_we = 0;
      repeat (20) @(posedge clk);
      @(negedge clk);

      check("core_q_drained", core_q.size() == 0, 32'(core_q.size()), 32'h0);
      check("dbg_q_drained", dbg_q.size() == 0, 32'(dbg_q.size()), 32'h0);
      check("mem_x0_zero", tb_mem[0] == 32'h0, tb_mem[0], 32'h0);
      for (int r = 1; r < 32; r++)
         check($sformatf("mem_x%0d", r), tb_mem[r] == ref_rf[r], tb_mem[r], ref_rf[r]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
